// File: rtl/rv_pkg.sv
//------------------------------------------------------------------------------
// rv_pkg
//   Shared RV32 execute-stage definitions: machine width, divide/remainder
//   operation encoding and the single-cycle ALU operation codes.
//   No ports (package).
//------------------------------------------------------------------------------
package rv_pkg;

   localparam int XLEN = 32;

   // RV32M divide/remainder selector as presented on div_op
   typedef enum logic [1:0] {
      OP_DIV  = 2'b00,
      OP_DIVU = 2'b01,
      OP_REM  = 2'b10,
      OP_REMU = 2'b11
   } div_op_t;

   // Single-cycle ALU operation codes
   localparam logic [3:0] ALU_ADD    = 4'd0;
   localparam logic [3:0] ALU_SUB    = 4'd1;
   localparam logic [3:0] ALU_SLL    = 4'd2;
   localparam logic [3:0] ALU_SLT    = 4'd3;
   localparam logic [3:0] ALU_SLTU   = 4'd4;
   localparam logic [3:0] ALU_XOR    = 4'd5;
   localparam logic [3:0] ALU_SRL    = 4'd6;
   localparam logic [3:0] ALU_SRA    = 4'd7;
   localparam logic [3:0] ALU_OR     = 4'd8;
   localparam logic [3:0] ALU_AND    = 4'd9;
   localparam logic [3:0] ALU_MUL    = 4'd10;
   localparam logic [3:0] ALU_MULH   = 4'd11;
   localparam logic [3:0] ALU_MULHSU = 4'd12;
   localparam logic [3:0] ALU_MULHU  = 4'd13;

   // DIV and REM treat their operands as two's-complement values
   function automatic logic div_op_is_signed(input div_op_t op);
      return (op == OP_DIV) || (op == OP_REM);
   endfunction

   // REM and REMU return the remainder instead of the quotient
   function automatic logic div_op_is_rem(input div_op_t op);
      return (op == OP_REM) || (op == OP_REMU);
   endfunction

endpackage

// File: rtl/div_step.sv
//------------------------------------------------------------------------------
// div_step
//   One combinational radix-2 restoring-division iteration. The quotient
//   register doubles as the dividend shift register: its MSB is shifted into
//   the partial remainder and the new quotient bit enters at its LSB.
// Ports
//   rem      in   WIDTH  partial remainder (always < divisor)
//   quo      in   WIDTH  remaining dividend bits / quotient bits so far
//   divisor  in   WIDTH  divisor magnitude
//   rem_out  out  WIDTH  updated partial remainder
//   quo_out  out  WIDTH  updated quotient/dividend register
//------------------------------------------------------------------------------
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem,
   input  logic [WIDTH-1:0] quo,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_out,
   output logic [WIDTH-1:0] quo_out
);

   logic [WIDTH:0] rem_shift_s;
   logic [WIDTH:0] diff_s;

   // Trial subtraction and restore decision for one quotient bit
   always_comb begin
      // The shifted remainder keeps all WIDTH bits of rem: with a divisor
      // above 2^(WIDTH-1) the partial remainder can itself exceed that, so
      // dropping its top bit would corrupt the result.
      rem_shift_s = {rem, quo[WIDTH-1]};
      diff_s      = rem_shift_s - {1'b0, divisor};
      // rem_shift_s < 2*divisor, so a non-negative difference always fits in
      // WIDTH bits and diff_s[WIDTH] is a pure borrow flag.
      if (diff_s[WIDTH] == 1'b0) begin
         rem_out = diff_s[WIDTH-1:0];
         quo_out = {quo[WIDTH-2:0], 1'b1};
      end else begin
         rem_out = rem_shift_s[WIDTH-1:0];
         quo_out = {quo[WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/div_sequencer.sv
//------------------------------------------------------------------------------
// div_sequencer
//   Multi-cycle RV32M DIV/DIVU/REM/REMU unit for the execute stage. Accepts one
//   operation per start handshake, runs WIDTH restoring-division iterations on
//   operand magnitudes, applies the sign fix-up and offers the result on a
//   valid/ready handshake. Divide-by-zero and signed overflow are answered at
//   accept time without iterating. busy stalls the pipeline while not idle.
// Ports
//   clk           in   1      rising-edge clock
//   rst           in   1      synchronous active-high reset
//   start         in   1      launch request, taken only while ready=1
//   div_op        in   2      operation select (rv_pkg::div_op_t)
//   inA           in   WIDTH  dividend (rs1)
//   inB           in   WIDTH  divisor (rs2)
//   flush         in   1      abort in-flight operation / discard result
//   ready         out  1      idle, start will be accepted
//   busy          out  1      not idle (stall request)
//   result_valid  out  1      result is presented
//   result_ready  in   1      consumer takes the result this cycle
//   result        out  WIDTH  quotient or remainder
//------------------------------------------------------------------------------
module div_sequencer
   import rv_pkg::*;
#(
   parameter int WIDTH = XLEN
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       div_op,
   input  logic [WIDTH-1:0] inA,
   input  logic [WIDTH-1:0] inB,
   input  logic             flush,
   output logic             ready,
   output logic             busy,
   output logic             result_valid,
   input  logic             result_ready,
   output logic [WIDTH-1:0] result
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_BUSY = 2'b01;
   localparam logic [1:0] ST_DONE = 2'b10;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   localparam logic [WIDTH-1:0] W_ZERO = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] W_ONES = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] W_MIN  = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] W_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

   // Two's-complement negation
   function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
      return ~v + W_ONE;
   endfunction

   // Registered state
   logic [1:0]       state_q,     state_d;
   logic [CNT_W-1:0] cnt_q,       cnt_d;
   logic [WIDTH-1:0] rem_q,       rem_d;
   logic [WIDTH-1:0] quo_q,       quo_d;
   logic [WIDTH-1:0] divisor_q,   divisor_d;
   logic             neg_quo_q,   neg_quo_d;
   logic             neg_rem_q,   neg_rem_d;
   logic             sel_rem_q,   sel_rem_d;
   logic [WIDTH-1:0] result_q,    result_d;
   logic             ready_q,     ready_d;
   logic             busy_q,      busy_d;
   logic             valid_q,     valid_d;

   // Combinational decode
   div_op_t          op_s;
   logic             is_signed_s;
   logic             is_rem_s;
   logic             accept_s;
   logic             div_zero_s;
   logic             overflow_s;
   logic [WIDTH-1:0] mag_a_s;
   logic [WIDTH-1:0] mag_b_s;
   logic [WIDTH-1:0] step_rem_s;
   logic [WIDTH-1:0] step_quo_s;
   logic [WIDTH-1:0] fix_quo_s;
   logic [WIDTH-1:0] fix_rem_s;

   div_step #(
      .WIDTH   (WIDTH)
   ) u_div_step (
      .rem     (rem_q),
      .quo     (quo_q),
      .divisor (divisor_q),
      .rem_out (step_rem_s),
      .quo_out (step_quo_s)
   );

   // Operation decode, operand magnitudes and special-case detection
   always_comb begin
      op_s        = div_op_t'(div_op);
      is_signed_s = div_op_is_signed(op_s);
      is_rem_s    = div_op_is_rem(op_s);
      accept_s    = start & ~flush & (state_q == ST_IDLE);
      div_zero_s  = (inB == W_ZERO);
      overflow_s  = is_signed_s & (inA == W_MIN) & (inB == W_ONES);
      if (is_signed_s & inA[WIDTH-1]) begin
         mag_a_s = neg_w(inA);
      end else begin
         mag_a_s = inA;
      end
      if (is_signed_s & inB[WIDTH-1]) begin
         mag_b_s = neg_w(inB);
      end else begin
         mag_b_s = inB;
      end
   end

   // Sign fix-up applied to the outputs of the final iteration
   always_comb begin
      if (neg_quo_q) begin
         fix_quo_s = neg_w(step_quo_s);
      end else begin
         fix_quo_s = step_quo_s;
      end
      if (neg_rem_q) begin
         fix_rem_s = neg_w(step_rem_s);
      end else begin
         fix_rem_s = step_rem_s;
      end
   end

   // Next-state logic: FSM, iteration counter, operand latch and result
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      divisor_d = divisor_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      sel_rem_d = sel_rem_q;
      result_d  = result_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               sel_rem_d = is_rem_s;
               neg_quo_d = is_signed_s & (inA[WIDTH-1] ^ inB[WIDTH-1]);
               neg_rem_d = is_signed_s & inA[WIDTH-1];
               if (div_zero_s) begin
                  // RISC-V: x/0 = all ones, x%0 = x (raw dividend)
                  result_d = is_rem_s ? inA : W_ONES;
                  state_d  = ST_DONE;
               end else if (overflow_s) begin
                  // RISC-V: MIN/-1 = MIN, MIN%-1 = 0
                  result_d = is_rem_s ? W_ZERO : inA;
                  state_d  = ST_DONE;
               end else begin
                  rem_d     = W_ZERO;
                  quo_d     = mag_a_s;
                  divisor_d = mag_b_s;
                  cnt_d     = CNT_LAST;
                  state_d   = ST_BUSY;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (flush) begin
               state_d = ST_IDLE;
            end else begin
               rem_d = step_rem_s;
               quo_d = step_quo_s;
               // The iteration with the counter at zero produces bit 0; its
               // signed result is registered in the same edge.
               if (cnt_q == CNT_ZERO) begin
                  result_d = sel_rem_q ? fix_rem_s : fix_quo_s;
                  state_d  = ST_DONE;
               end else begin
                  cnt_d = cnt_q - CNT_ONE;
               end
            end
         end
         ST_DONE: begin
            // flush with result_ready also lands here: data counts as discarded
            if (flush | result_ready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Handshake outputs registered from the next state so they match state_q
   always_comb begin
      ready_d = (state_d == ST_IDLE);
      busy_d  = (state_d != ST_IDLE);
      valid_d = (state_d == ST_DONE);
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= CNT_ZERO;
         rem_q     <= W_ZERO;
         quo_q     <= W_ZERO;
         divisor_q <= W_ZERO;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         sel_rem_q <= 1'b0;
         result_q  <= W_ZERO;
         ready_q   <= 1'b1;
         busy_q    <= 1'b0;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         divisor_q <= divisor_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         sel_rem_q <= sel_rem_d;
         result_q  <= result_d;
         ready_q   <= ready_d;
         busy_q    <= busy_d;
         valid_q   <= valid_d;
      end
   end

   assign ready        = ready_q;
   assign busy         = busy_q;
   assign result_valid = valid_q;
   assign result       = result_q;

endmodule

// File: tb/tb_div_sequencer.sv
//------------------------------------------------------------------------------
// tb_div_sequencer
//   Self-checking bench for div_sequencer: directed RV32M cases, randomized
//   operations against an arithmetic reference model, flush, back-pressure
//   and reset scenarios.
//------------------------------------------------------------------------------
module tb_div_sequencer;

   localparam int W = 32;
   localparam logic [1:0] T_DIV  = 2'b00;
   localparam logic [1:0] T_DIVU = 2'b01;
   localparam logic [1:0] T_REM  = 2'b10;
   localparam logic [1:0] T_REMU = 2'b11;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [1:0]   div_op;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic         flush;
   logic         ready;
   logic         busy;
   logic         result_valid;
   logic         result_ready;
   logic [W-1:0] result;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   div_sequencer #(.WIDTH(W)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .div_op       (div_op),
      .inA          (in_a),
      .inB          (in_b),
      .flush        (flush),
      .ready        (ready),
      .busy         (busy),
      .result_valid (result_valid),
      .result_ready (result_ready),
      .result       (result)
   );

   // RISC-V divide semantics computed with plain arithmetic
   function automatic logic [W-1:0] model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      logic         sgn;
      logic [W-1:0] q;
      logic [W-1:0] r;
      sgn = (op == T_DIV) || (op == T_REM);
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF;
         r = a;
      end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = a;
         r = 32'd0;
      end else if (sgn) begin
         q = $signed(a) / $signed(b);
         r = $signed(a) % $signed(b);
      end else begin
         q = a / b;
         r = a % b;
      end
      return (op == T_REM || op == T_REMU) ? r : q;
   endfunction

   // Cycles from the start cycle to the first result_valid cycle
   function automatic int model_latency(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      logic sgn;
      sgn = (op == T_DIV) || (op == T_REM);
      if (b == 32'd0 || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
      return W + 1;
   endfunction

   // Stimulus only: issue one op with result_ready=1 and wait (bounded) for the result
   task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] res, output int lat, output logic busy1);
      div_op = op; in_a = a; in_b = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; in_a = $urandom; in_b = $urandom; div_op = 2'($urandom_range(0, 3));
      lat = 1; busy1 = busy;
      while (!result_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      res = result;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; flush = 1'b0; result_ready = 1'b1;
      div_op = T_DIV; in_a = 32'd0; in_b = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", result_valid); end
      checks++; if (result !== 32'd0) begin errors++; $display("FAIL reset_result: got %h want 0", result); end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_unsigned_basic();
      logic [W-1:0] res; int lat; logic b1;
      run_op(T_DIVU, 32'd100, 32'd7, res, lat, b1);
      checks++; if (res !== 32'd14) begin errors++; $display("FAIL divu_100_7: got %h want %h", res, 32'd14); end
      checks++; if (lat != 33) begin errors++; $display("FAIL divu_latency: got %0d want 33", lat); end
      checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL divu_busy: got %b want 1", b1); end
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL divu_idle_after: got %b want 1", ready); end
      run_op(T_REMU, 32'd100, 32'd7, res, lat, b1);
      checks++; if (res !== 32'd2) begin errors++; $display("FAIL remu_100_7: got %h want %h", res, 32'd2); end
      checks++; if (lat != 33) begin errors++; $display("FAIL remu_latency: got %0d want 33", lat); end
      run_op(T_DIVU, 32'd0, 32'd9, res, lat, b1);
      checks++; if (res !== 32'd0 || lat != 33) begin errors++; $display("FAIL divu_zero_dividend: got %h lat %0d want 0 lat 33", res, lat); end
   endtask

   task automatic test_signed();
      logic [1:0]   ops [4] = '{T_DIV, T_REM, T_DIV, T_REM};
      logic [W-1:0] as  [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'd7};
      logic [W-1:0] bs  [4] = '{32'd2, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
      logic [W-1:0] exp [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd1};
      logic [W-1:0] res; int lat; logic b1;
      for (int i = 0; i < 4; i++) begin
         run_op(ops[i], as[i], bs[i], res, lat, b1);
         checks++;
         if (res !== exp[i] || lat != 33) begin
            errors++; $display("FAIL signed_%0d: got %h lat %0d want %h lat 33", i, res, lat, exp[i]);
         end
      end
   endtask

   task automatic test_special();
      logic [1:0]   ops [4] = '{T_DIVU, T_REMU, T_DIV, T_REM};
      logic [W-1:0] as  [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
      logic [W-1:0] bs  [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [W-1:0] exp [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
      logic [W-1:0] res; int lat; logic b1;
      for (int i = 0; i < 4; i++) begin
         run_op(ops[i], as[i], bs[i], res, lat, b1);
         checks++;
         if (res !== exp[i] || lat != 1) begin
            errors++; $display("FAIL special_%0d: got %h lat %0d want %h lat 1", i, res, lat, exp[i]);
         end
         checks++;
         if (b1 !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL special_busy_%0d: got busy %b then %b want 1 then 0", i, b1, busy);
         end
      end
   endtask

   task automatic test_random();
      logic [1:0] op; logic [W-1:0] a, b, res; int lat, kind; logic b1;
      for (int i = 0; i < 60; i++) begin
         op = 2'($urandom_range(0, 3));
         kind = $urandom_range(0, 9);
         a = $urandom; b = $urandom;
         case (kind)
            0: b = 32'd0;
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: begin a = $urandom_range(0, 255); b = $urandom_range(1, 15); end
            3: a = 32'd0;
            4: begin a = $urandom | 32'hC000_0000; b = $urandom | 32'h8000_0001; end
            5: begin a = $urandom | 32'h8000_0000; b = $urandom_range(1, 7); end
            default: ;
         endcase
         run_op(op, a, b, res, lat, b1);
         checks++;
         if (res !== model(op, a, b) || lat != model_latency(op, a, b)) begin
            errors++;
            $display("FAIL random_%0d op %0d a %h b %h: got %h lat %0d want %h lat %0d",
                     i, op, a, b, res, lat, model(op, a, b), model_latency(op, a, b));
         end
      end
   endtask

   task automatic test_flush();
      logic [W-1:0] res; int lat, seen; logic b1;
      div_op = T_DIVU; in_a = 32'd1000; in_b = 32'd3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      checks++;
      if (ready !== 1'b1 || busy !== 1'b0 || result_valid !== 1'b0) begin
         errors++; $display("FAIL flush_busy: got ready %b busy %b valid %b want 1 0 0", ready, busy, result_valid);
      end
      seen = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1;
         if (result_valid === 1'b1) seen++;
      end
      checks++; if (seen != 0) begin errors++; $display("FAIL flush_no_result: got %0d valid cycles want 0", seen); end
      run_op(T_DIVU, 32'd9, 32'd3, res, lat, b1);
      checks++; if (res !== 32'd3 || lat != 33) begin errors++; $display("FAIL flush_next_op: got %h lat %0d want 3 lat 33", res, lat); end
      // flush and start together in IDLE: no accept
      div_op = T_DIVU; in_a = 32'd50; in_b = 32'd5; start = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; flush = 1'b0;
      checks++; if (ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL flush_start_idle: got ready %b busy %b want 1 0", ready, busy); end
      // flush together with result_ready in DONE
      result_ready = 1'b0;
      div_op = T_DIVU; in_a = 32'd5; in_b = 32'd0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL flush_done_setup: got valid %b want 1", result_valid); end
      flush = 1'b1; result_ready = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      checks++;
      if (ready !== 1'b1 || busy !== 1'b0 || result_valid !== 1'b0) begin
         errors++; $display("FAIL flush_done: got ready %b busy %b valid %b want 1 0 0", ready, busy, result_valid);
      end
   endtask

   task automatic test_backpressure();
      logic [W-1:0] a, b, exp, res; int lat; logic b1;
      a = $urandom; b = $urandom_range(1, 5000); exp = a / b;
      result_ready = 1'b0;
      div_op = T_DIVU; in_a = a; in_b = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; lat = 1;
      while (!result_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      checks++; if (lat != 33) begin errors++; $display("FAIL bp_latency: got %0d want 33", lat); end
      checks++; if (result !== exp) begin errors++; $display("FAIL bp_result: got %h want %h", result, exp); end
      for (int k = 0; k < 5; k++) begin
         div_op = T_DIVU; in_a = $urandom; in_b = 32'd1; start = 1'b1;
         @(posedge clk); #1;
         checks++;
         if (result_valid !== 1'b1 || result !== exp || ready !== 1'b0) begin
            errors++; $display("FAIL bp_hold_%0d: got valid %b ready %b result %h want 1 0 %h", k, result_valid, ready, result, exp);
         end
      end
      start = 1'b0; result_ready = 1'b1;
      @(posedge clk); #1;
      checks++; if (result_valid !== 1'b0 || ready !== 1'b1) begin errors++; $display("FAIL bp_release: got valid %b ready %b want 0 1", result_valid, ready); end
      run_op(T_DIVU, 32'd77, 32'd7, res, lat, b1);
      checks++; if (res !== 32'd11 || lat != 33) begin errors++; $display("FAIL bp_next_op: got %h lat %0d want 11 lat 33", res, lat); end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] res; int lat; logic b1;
      // run_op returns in the cycle after the DONE->IDLE edge, so these start immediately
      run_op(T_REMU, 32'd1001, 32'd10, res, lat, b1);
      checks++; if (res !== 32'd1 || lat != 33) begin errors++; $display("FAIL b2b_first: got %h lat %0d want 1 lat 33", res, lat); end
      run_op(T_DIV, 32'hFFFF_FF9C, 32'd7, res, lat, b1);
      checks++; if (res !== 32'hFFFF_FFF2 || lat != 33) begin errors++; $display("FAIL b2b_second: got %h lat %0d want fffffff2 lat 33", res, lat); end
   endtask

   task automatic test_reset_mid();
      div_op = T_DIVU; in_a = 32'd12345; in_b = 32'd6; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++;
      if (ready !== 1'b1 || busy !== 1'b0 || result_valid !== 1'b0 || result !== 32'd0) begin
         errors++; $display("FAIL reset_mid: got ready %b busy %b valid %b result %h want 1 0 0 0", ready, busy, result_valid, result);
      end
   endtask

   initial begin
      test_reset();
      test_unsigned_basic();
      test_signed();
      test_special();
      test_random();
      test_flush();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
